// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: instruction codes, status codes and the
// pipeline-control state type used by the hazard/halt controller.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones maximum instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86 pipeline hazard controller: per-stage stall/bubble generation, CC write
// gating, RUN/DRAIN/HALTED halt sequencing and saturating performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       D_opcode,
  input  logic [7:0]       E_opcode,
  input  logic [7:0]       M_opcode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  input  logic             dbg_freeze,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc_en,
  output logic             halted,
  output logic [1:0]       halt_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  logic [3:0]  d_icode, e_icode, m_icode;
  logic        load_use, ret_in_pipe, mispredict, exc_m, exc_w;
  logic        normal_run;
  logic        cyc_inc, lu_inc, mp_inc, ret_inc;
  logic        unused_ifun;
  ctrl_state_t state, state_next;

  assign d_icode     = D_opcode[7:4];
  assign e_icode     = E_opcode[7:4];
  assign m_icode     = M_opcode[7:4];
  assign unused_ifun = ^{D_opcode[3:0], E_opcode[3:0], M_opcode[3:0]};

  assign load_use    = ((e_icode == I_MRMOVQ) || (e_icode == I_POPQ)) &&
                       (E_dstM != RNONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign ret_in_pipe = (d_icode == I_RET) || (e_icode == I_RET) || (m_icode == I_RET);
  assign mispredict  = (e_icode == I_JXX) && !e_Cnd;
  assign exc_m       = (m_stat != S_AOK);
  assign exc_w       = (W_stat != S_AOK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      halt_stat <= S_AOK;
    end else begin
      state <= state_next;
      if ((state != HALTED) && (state_next == HALTED)) begin
        halt_stat <= W_stat;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (!dbg_freeze) begin
      case (state)
        RUN: begin
          if (exc_w)      state_next = HALTED;
          else if (exc_m) state_next = DRAIN;
        end
        DRAIN: begin
          if (exc_w) state_next = HALTED;
        end
        HALTED:  state_next = HALTED;
        default: state_next = RUN;
      endcase
    end
  end

  assign halted = (state == HALTED);

  // Priority: debug freeze, then HALTED, then exception drain, then hazards.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    if (dbg_freeze || (state == HALTED)) begin
      {F_stall, D_stall, E_stall, M_stall, W_stall} = 5'b11111;
    end else if ((state == DRAIN) || exc_m || exc_w) begin
      F_stall  = 1'b1;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = exc_w;
    end else begin
      F_stall  = load_use | ret_in_pipe;
      D_stall  = load_use;
      D_bubble = mispredict | (ret_in_pipe & ~load_use);
      E_bubble = mispredict | load_use;
    end
  end

  assign normal_run = !dbg_freeze && (state == RUN) && !exc_m && !exc_w;
  assign set_cc_en  = normal_run && (e_icode == I_OPQ);

  assign cyc_inc = !dbg_freeze && ((state == RUN) || (state == DRAIN));
  assign lu_inc  = normal_run && load_use;
  assign mp_inc  = normal_run && mispredict;
  assign ret_inc = normal_run && ret_in_pipe && !load_use;

  sat_counter #(.W(CNT_W)) u_cyc (.clk(clk), .rst(rst), .inc(cyc_inc), .count(cyc_cnt));
  sat_counter #(.W(CNT_W)) u_lu  (.clk(clk), .rst(rst), .inc(lu_inc),  .count(lu_cnt));
  sat_counter #(.W(CNT_W)) u_mp  (.clk(clk), .rst(rst), .inc(mp_inc),  .count(mp_cnt));
  sat_counter #(.W(CNT_W)) u_ret (.clk(clk), .rst(rst), .inc(ret_inc), .count(ret_cnt));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (CNT_W=4 build) against a behavioural model
// of the hazard rules, halt sequencing and saturating counters.
module tb_pipe_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    D_opcode, E_opcode, M_opcode;
  logic [3:0]    d_srcA, d_srcB, E_dstM;
  logic          e_Cnd;
  logic [1:0]    m_stat, W_stat;
  logic          dbg_freeze;
  logic          F_stall, D_stall, E_stall, M_stall, W_stall;
  logic          D_bubble, E_bubble, M_bubble, set_cc_en, halted;
  logic [1:0]    halt_stat;
  logic [CW-1:0] cyc_cnt, lu_cnt, mp_cnt, ret_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_halted, m_drain;
  logic [1:0]    m_hstat;
  logic [CW-1:0] m_cyc, m_lu, m_mp, m_ret;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .D_opcode(D_opcode), .E_opcode(E_opcode), .M_opcode(M_opcode),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat), .dbg_freeze(dbg_freeze),
    .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall),
    .W_stall(W_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc_en(set_cc_en), .halted(halted), .halt_stat(halt_stat),
    .cyc_cnt(cyc_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .ret_cnt(ret_cnt)
  );

  wire [8:0] ctrl_vec = {F_stall, D_stall, E_stall, M_stall, W_stall,
                         D_bubble, E_bubble, M_bubble, set_cc_en};

  function automatic bit f_lu();
    int ei = int'(E_opcode[7:4]);
    return ((ei == 5) || (ei == 11)) && (E_dstM != 4'hF) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  endfunction

  function automatic bit f_ret();
    return (D_opcode[7:4] == 4'h9) || (E_opcode[7:4] == 4'h9) || (M_opcode[7:4] == 4'h9);
  endfunction

  function automatic bit f_mp();
    return (E_opcode[7:4] == 4'h7) && !e_Cnd;
  endfunction

  function automatic bit f_norm();
    return !dbg_freeze && !m_halted && !m_drain && (m_stat == 0) && (W_stat == 0);
  endfunction

  // Expected {F,D,E,M,W stall, D,E,M bubble, set_cc_en}
  function automatic logic [8:0] exp_ctrl();
    bit lu = f_lu();
    bit rt = f_ret();
    bit mp = f_mp();
    if (dbg_freeze || m_halted) return 9'b11111_000_0;
    if (m_drain || (m_stat != 0) || (W_stat != 0))
      return {4'b1000, (W_stat != 0), 3'b111, 1'b0};
    return {lu | rt, lu, 3'b000, mp | (rt & !lu), mp | lu, 1'b0,
            f_norm() && (E_opcode[7:4] == 4'h6)};
  endfunction

  function automatic logic [CW-1:0] sat_inc(logic [CW-1:0] v, bit en);
    return (en && (v != {CW{1'b1}})) ? v + 1'b1 : v;
  endfunction

  task automatic model_clear();
    m_halted = 0; m_drain = 0; m_hstat = 0;
    m_cyc = 0; m_lu = 0; m_mp = 0; m_ret = 0;
  endtask

  task automatic model_step();
    bit norm = f_norm();
    bit lu   = f_lu();
    if (!dbg_freeze && !m_halted) begin
      m_cyc = sat_inc(m_cyc, 1);
      m_lu  = sat_inc(m_lu,  norm && lu);
      m_mp  = sat_inc(m_mp,  norm && f_mp());
      m_ret = sat_inc(m_ret, norm && f_ret() && !lu);
      if (W_stat != 0) begin
        m_halted = 1; m_drain = 0; m_hstat = W_stat;
      end else if (!m_drain && (m_stat != 0)) begin
        m_drain = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_opcode = 8'h10; E_opcode = 8'h10; M_opcode = 8'h10;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
    m_stat = 2'd0; W_stat = 2'd0; dbg_freeze = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if ({halted, halt_stat, cyc_cnt, lu_cnt, mp_cnt, ret_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got h=%b hs=%0d cyc=%0d lu=%0d mp=%0d ret=%0d exp all 0",
               halted, halt_stat, cyc_cnt, lu_cnt, mp_cnt, ret_cnt);
    end
    // Controls stay live while reset is held.
    E_opcode = 8'h50; E_dstM = 4'h2; d_srcA = 4'h2;
    #1;
    n_checks++;
    if (ctrl_vec !== exp_ctrl()) begin
      n_fail++;
      $display("FAIL reset_live_ctrl got %b exp %b", ctrl_vec, exp_ctrl());
    end
    $display("reset: ctrl=%b", ctrl_vec);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    idle_inputs();
    E_opcode = 8'h50; E_dstM = 4'h3; d_srcB = 4'h3; D_opcode = 8'h60;
    #1;
    n_checks++;
    if (ctrl_vec !== 9'b11000_010_0 || ctrl_vec !== exp_ctrl()) begin
      n_fail++;
      $display("FAIL load_use_ctrl got %b exp %b", ctrl_vec, 9'b11000_010_0);
    end
    tick();
    n_checks++;
    if (lu_cnt !== 4'd1 || lu_cnt !== m_lu) begin
      n_fail++;
      $display("FAIL load_use_cnt got %0d exp 1", lu_cnt);
    end
    $display("load_use: ctrl=%b lu_cnt=%0d", ctrl_vec, lu_cnt);
  endtask

  task automatic test_mispredict_ret();
    do_reset();
    idle_inputs();
    E_opcode = 8'h70; e_Cnd = 1'b0; D_opcode = 8'h90;
    #1;
    n_checks++;
    if (ctrl_vec !== 9'b10000_110_0 || ctrl_vec !== exp_ctrl()) begin
      n_fail++;
      $display("FAIL mp_ret_ctrl got %b exp %b", ctrl_vec, 9'b10000_110_0);
    end
    tick();
    n_checks++;
    if (mp_cnt !== 4'd1 || ret_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL mp_ret_cnt got mp=%0d ret=%0d exp mp=1 ret=1", mp_cnt, ret_cnt);
    end
    // Load-use together with ret: D stalled, not bubbled.
    idle_inputs();
    E_opcode = 8'hB0; E_dstM = 4'h4; d_srcA = 4'h4; M_opcode = 8'h90;
    #1;
    n_checks++;
    if (ctrl_vec !== 9'b11000_010_0) begin
      n_fail++;
      $display("FAIL lu_ret_ctrl got %b exp %b", ctrl_vec, 9'b11000_010_0);
    end
    tick();
    n_checks++;
    if (ret_cnt !== 4'd1 || lu_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL lu_ret_cnt got ret=%0d lu=%0d exp ret=1 lu=1", ret_cnt, lu_cnt);
    end
    $display("mispredict_ret: mp=%0d ret=%0d lu=%0d", mp_cnt, ret_cnt, lu_cnt);
  endtask

  task automatic test_drain_halt();
    logic [CW-1:0] cyc_hold;
    do_reset();
    idle_inputs();
    m_stat = 2'd3; E_opcode = 8'h60;
    #1;
    n_checks++;
    if (ctrl_vec !== 9'b10000_111_0) begin
      n_fail++;
      $display("FAIL drain_entry_ctrl got %b exp %b", ctrl_vec, 9'b10000_111_0);
    end
    tick();
    m_stat = 2'd0;
    #1;
    n_checks++;
    if (ctrl_vec !== 9'b10000_111_0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_state got ctrl=%b halted=%b exp ctrl=100001110 halted=0", ctrl_vec, halted);
    end
    tick();
    W_stat = 2'd3;
    #1;
    n_checks++;
    if (ctrl_vec !== 9'b10001_111_0) begin
      n_fail++;
      $display("FAIL drain_wexc_ctrl got %b exp %b", ctrl_vec, 9'b10001_111_0);
    end
    tick();
    W_stat = 2'd0;
    #1;
    n_checks++;
    if (halted !== 1'b1 || halt_stat !== 2'd3 || ctrl_vec !== 9'b11111_000_0) begin
      n_fail++;
      $display("FAIL halted_state got h=%b hs=%0d ctrl=%b exp h=1 hs=3 ctrl=111110000",
               halted, halt_stat, ctrl_vec);
    end
    cyc_hold = cyc_cnt;
    repeat (3) tick();
    n_checks++;
    if (cyc_cnt !== cyc_hold || cyc_cnt !== m_cyc) begin
      n_fail++;
      $display("FAIL halted_cyc_frozen got %0d exp %0d", cyc_cnt, m_cyc);
    end
    $display("drain_halt: halted=%b halt_stat=%0d cyc=%0d", halted, halt_stat, cyc_cnt);
  endtask

  task automatic test_simul_exc();
    do_reset();
    idle_inputs();
    m_stat = 2'd1; W_stat = 2'd1;
    #1;
    n_checks++;
    if (W_stall !== 1'b1 || ctrl_vec !== exp_ctrl()) begin
      n_fail++;
      $display("FAIL simul_exc_ctrl got %b exp %b", ctrl_vec, exp_ctrl());
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (halted !== 1'b1 || halt_stat !== 2'd1) begin
      n_fail++;
      $display("FAIL simul_exc_halt got h=%b hs=%0d exp h=1 hs=1", halted, halt_stat);
    end
    $display("simul_exc: halted=%b halt_stat=%0d", halted, halt_stat);
  endtask

  task automatic test_freeze();
    do_reset();
    idle_inputs();
    E_opcode = 8'h50; E_dstM = 4'h1; d_srcA = 4'h1; dbg_freeze = 1'b1; m_stat = 2'd2;
    #1;
    n_checks++;
    if (ctrl_vec !== 9'b11111_000_0) begin
      n_fail++;
      $display("FAIL freeze_ctrl got %b exp %b", ctrl_vec, 9'b11111_000_0);
    end
    tick();
    tick();
    m_stat = 2'd0;
    n_checks++;
    if (lu_cnt !== 4'd0 || cyc_cnt !== 4'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_hold got lu=%0d cyc=%0d exp 0 0", lu_cnt, cyc_cnt);
    end
    dbg_freeze = 1'b0;
    #1;
    n_checks++;
    if (ctrl_vec !== 9'b11000_010_0) begin
      n_fail++;
      $display("FAIL unfreeze_ctrl got %b exp %b", ctrl_vec, 9'b11000_010_0);
    end
    tick();
    n_checks++;
    if (lu_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL unfreeze_cnt got %0d exp 1", lu_cnt);
    end
    $display("freeze: lu_cnt=%0d ctrl=%b", lu_cnt, ctrl_vec);
  endtask

  task automatic test_saturation();
    do_reset();
    idle_inputs();
    D_opcode = 8'h90;
    repeat (20) tick();
    n_checks++;
    if (cyc_cnt !== 4'd15 || ret_cnt !== 4'd15 || cyc_cnt !== m_cyc) begin
      n_fail++;
      $display("FAIL saturate got cyc=%0d ret=%0d exp 15 15", cyc_cnt, ret_cnt);
    end
    idle_inputs();
    W_stat = 2'd2;
    tick();
    W_stat = 2'd0;
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (halted !== 1'b0 || halt_stat !== 2'd0 || cyc_cnt !== 4'd0 || ret_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset got h=%b hs=%0d cyc=%0d ret=%0d exp all 0",
               halted, halt_stat, cyc_cnt, ret_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    $display("saturation: cyc=%0d after async reset", cyc_cnt);
  endtask

  task automatic test_random();
    logic [3:0] regs [5] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF};
    do_reset();
    for (int i = 0; i < 200; i++) begin
      D_opcode   = {4'(($urandom_range(0, 11))), 4'($urandom)};
      E_opcode   = {4'(($urandom_range(0, 11))), 4'($urandom)};
      M_opcode   = {4'(($urandom_range(0, 11))), 4'($urandom)};
      d_srcA     = regs[$urandom_range(0, 4)];
      d_srcB     = regs[$urandom_range(0, 4)];
      E_dstM     = regs[$urandom_range(0, 4)];
      e_Cnd      = 1'($urandom);
      m_stat     = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      W_stat     = ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      dbg_freeze = ($urandom_range(0, 9) == 0);
      #1;
      n_checks++;
      if (ctrl_vec !== exp_ctrl() || halted !== m_halted || halt_stat !== m_hstat ||
          cyc_cnt !== m_cyc || lu_cnt !== m_lu || mp_cnt !== m_mp || ret_cnt !== m_ret) begin
        n_fail++;
        $display("FAIL random[%0d] got ctrl=%b h=%b hs=%0d c=%0d/%0d/%0d/%0d exp ctrl=%b h=%b hs=%0d c=%0d/%0d/%0d/%0d",
                 i, ctrl_vec, halted, halt_stat, cyc_cnt, lu_cnt, mp_cnt, ret_cnt,
                 exp_ctrl(), m_halted, m_hstat, m_cyc, m_lu, m_mp, m_ret);
      end
      $display("random[%0d]: D=%h E=%h M=%h ctrl=%b halted=%b", i, D_opcode, E_opcode,
               M_opcode, ctrl_vec, halted);
      if (m_halted && ($urandom_range(0, 3) == 0)) do_reset();
      else tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_clear();
    test_reset();
    test_load_use();
    test_mispredict_ret();
    test_drain_halt();
    test_simul_exc();
    test_freeze();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard controller and halt sequencer for the five-stage Y86 core. It observes the instruction codes, register IDs, condition outcome and status codes of the D, E, M and W stages. From these it produces the per-stage stall and bubble controls that the pipeline registers consume, and it gates condition-code updates. It also runs a RUN/DRAIN/HALTED state machine that stops the machine cleanly on HLT/ADR/INS, and keeps saturating performance counters for cycles, load-use stalls, mispredicts and ret bubbles.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- D_opcode, E_opcode, M_opcode  in  8 each  stage opcodes; icode is bits [7:4]
- d_srcA, d_srcB  in  4 each  decode source registers; 4'hF means none
- E_dstM  in  4  load destination of the instruction in E
- e_Cnd  in  1  branch condition computed in execute
- m_stat, W_stat  in  2 each  status codes: 0 AOK, 1 HLT, 2 ADR, 3 INS
- dbg_freeze  in  1  debug hold of the whole pipeline
- F_stall, D_stall, E_stall, M_stall, W_stall  out  1 each  stage register hold
- D_bubble, E_bubble, M_bubble  out  1 each  stage register inject NOP (icode 1, dst 4'hF, stat AOK)
- set_cc_en  out  1  condition-code write enable
- halted  out  1  high in HALTED
- halt_stat  out  2  W_stat latched on entry to HALTED
- cyc_cnt, lu_cnt, mp_cnt, ret_cnt  out  CNT_W each  performance counters

## Operation
Derived terms:
- load_use: E icode ∈ {5 MRMOVQ, B POPQ}, E_dstM ≠ F, and E_dstM equals d_srcA or d_srcB.
- ret_in_pipe: icode 9 present in D, E or M.
- mispredict: E icode = 7 and e_Cnd = 0.
- exc_m = (m_stat ≠ 0); exc_w = (W_stat ≠ 0).

State machine (enum RUN, DRAIN, HALTED):
- RUN → HALTED when exc_w.
- RUN → DRAIN when exc_m and not exc_w.
- DRAIN → HALTED when exc_w.
- HALTED is left only by rst.
- No transition occurs while dbg_freeze=1.
- On entry to HALTED, halt_stat ← W_stat.

Controls, applied in priority order (first match wins):
1. dbg_freeze=1: all five stalls = 1; all bubbles = 0; set_cc_en = 0.
2. HALTED: all five stalls = 1; all bubbles = 0.
3. DRAIN, or RUN with exc_m or exc_w: F_stall = 1; D_bubble = 1; E_bubble = 1; M_bubble = 1; W_stall = exc_w.
4. RUN, normal hazard resolution:
   - F_stall = load_use | ret_in_pipe
   - D_stall = load_use
   - D_bubble = mispredict | (ret_in_pipe & ~load_use)
   - E_bubble = mispredict | load_use
   - E_stall = M_stall = W_stall = M_bubble = 0
- A stall and a bubble are never both high for the same stage.
- set_cc_en = (E icode = 6 OPQ) & RUN & ~exc_m & ~exc_w & ~dbg_freeze.

Counters (all saturating at 2^CNT_W−1; all hold while dbg_freeze=1 or in HALTED):
- cyc_cnt increments every cycle in RUN or DRAIN.
- In RUN with no exception:
  - lu_cnt increments on load_use.
  - mp_cnt increments on mispredict.
  - ret_cnt increments on ret_in_pipe & ~load_use.

## Timing
- All stall/bubble/set_cc_en outputs are combinational from the inputs and the current state, with zero-cycle latency. Pipeline registers sample them at the same edge.
- State, halt_stat and counters update at posedge clk.
- Reset values: state RUN, halted 0, halt_stat 0, all counters 0.
- During reset, controls evaluate as RUN with the live inputs.
- rst asserted mid-DRAIN or in HALTED returns to RUN asynchronously; counters clear immediately.
- Simultaneous exc_m and exc_w in RUN: go directly to HALTED; halt_stat = W_stat.
- Mispredict together with ret in D: F_stall, D_bubble and E_bubble all 1.
- Load-use together with ret: D is stalled, not bubbled.
- Counter at maximum plus an increment event: the counter holds at its maximum.

## Structure
- Shared package y86_pkg holds:
  - icode constants (HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B)
  - stat codes (AOK 0, HLT 1, ADR 2, INS 3)
  - RNONE = 4'hF
  - the ctrl_state_t enum
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated four times.

## Test plan
- MRMOVQ in E with E_dstM=3, d_srcB=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; lu_cnt goes 0→1 next edge.
- JXX in E with e_Cnd=0 and RET in D → D_bubble=1, E_bubble=1, F_stall=1; mp_cnt=1 and ret_cnt=1 after the edge.
- m_stat=3 in RUN → M_bubble=1 this cycle, DRAIN next. Then W_stat=3 → HALTED, halted=1, halt_stat=3, all stalls high, cyc_cnt frozen.
- m_stat=1 and W_stat=1 in the same cycle → HALTED after one edge; W_stall=1 in that cycle.
- dbg_freeze=1 with a load-use present → all stalls 1, no bubbles, lu_cnt unchanged. Deassert freeze → normal load-use controls resume.
- Preload a counter to 2^CNT_W−1 (CNT_W=4 build), then run 3 cycles → cyc_cnt stays 15. Assert rst in HALTED → RUN and all counters 0 without a clock edge.
